// File: rtl/obufds_gte_refclk_ctrl.sv
// Round-robin owner arbitration and glitch-free CEB / TX-path sequencing for a shared GTE3 refclk OBUFDS.
// Optional ACTIVE-hold watchdog: define OBUFDS_GTE_REFCLK_CTRL_WATCHDOG_EN.
`timescale 1ns/1ps

`ifdef OBUFDS_GTE_REFCLK_CTRL_WATCHDOG_EN
module obufds_gte_refclk_req_lane (
   input  logic CLK,
   input  logic RSTB,
   input  logic req,
   input  logic force_out,
   output logic elig
);
   logic blocked;

   // A forced-out owner stays ineligible until its request has dropped once.
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB)          blocked <= 1'b0;
      else if (force_out) blocked <= 1'b1;
      else if (!req)      blocked <= 1'b0;
   end

   assign elig = req & ~blocked;
endmodule
`endif

module obufds_gte_refclk_ctrl #(
   parameter int NUM_REQ       = 4,
   parameter int CFG_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 16,
   parameter int OFF_CYCLES    = 8,
   parameter int MAX_HOLD      = 1024
) (
   input  logic                 CLK,
   input  logic                 RSTB,
   input  logic [NUM_REQ-1:0]   REQ,
   input  logic [5*NUM_REQ-1:0] REQ_ICNTL,
   output logic [NUM_REQ-1:0]   GNT,
   output logic                 READY,
   output logic                 CEB,
   output logic                 EN_TX_PATH,
   output logic [4:0]           ICNTL_TX,
   output logic                 TIMEOUT
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int M0 = (CFG_CYCLES > SETTLE_CYCLES) ? CFG_CYCLES : SETTLE_CYCLES;
   localparam int M1 = (M0 > OFF_CYCLES) ? M0 : OFF_CYCLES;
   localparam int M2 = (M1 > MAX_HOLD) ? M1 : MAX_HOLD;
   localparam int CW = $clog2(M2) + 1;

   localparam logic [CW-1:0] CFG_LD = CW'(CFG_CYCLES - 1);
   localparam logic [CW-1:0] SET_LD = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] OFF_LD = CW'(OFF_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_CFG, S_EN, S_ACTIVE, S_DIS} state_t;

   typedef struct packed {
      logic [NUM_REQ-1:0] gnt;
      logic               ready;
      logic               ceb;
      logic               en;
      logic [4:0]         icntl;
   } pad_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           owner_q, owner_d, ptr_q, ptr_d;
   pad_t                    pad_q, pad_d;
   logic [NUM_REQ-1:0][4:0] icntl_arr;
   logic [NUM_REQ-1:0]      elig;
   logic [NUM_REQ-1:0]      own_1h;
   logic                    own_req;
   logic                    pick_vld;
   logic [IW-1:0]           pick_idx, ptr_nxt;
   logic                    rel;

   assign icntl_arr = REQ_ICNTL;
   assign own_req   = REQ[owner_q];
   assign own_1h    = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

`ifdef OBUFDS_GTE_REFCLK_CTRL_WATCHDOG_EN
   localparam logic [CW-1:0] HOLD_LD = CW'(MAX_HOLD - 1);
   logic force_out, to_q, to_d;

   genvar gi;
   for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      obufds_gte_refclk_req_lane u_lane (
         .CLK       (CLK),
         .RSTB      (RSTB),
         .req       (REQ[gi]),
         .force_out (force_out && (owner_q == IW'(gi))),
         .elig      (elig[gi])
      );
   end
   assign TIMEOUT = to_q;
`else
   assign elig    = REQ;
   assign TIMEOUT = 1'b0;
`endif

   // Scan downward so the last hit is the first eligible index at or after ptr.
   always_comb begin
      int idx;
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (elig[idx]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(idx);
         end
      end
      ptr_nxt = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      pad_d   = pad_q;
      rel     = !own_req;
`ifdef OBUFDS_GTE_REFCLK_CTRL_WATCHDOG_EN
      to_d      = to_q;
      force_out = 1'b0;
`endif
      case (state_q)
         S_IDLE: if (pick_vld) begin
            state_d     = S_CFG;
            cnt_d       = CFG_LD;
            owner_d     = pick_idx;
            ptr_d       = ptr_nxt;
            pad_d.en    = 1'b1;
            pad_d.icntl = icntl_arr[pick_idx];
         end
         S_CFG: begin
            if (rel) begin
               state_d = S_DIS;
               cnt_d   = OFF_LD;
            end else if (cnt_q == '0) begin
               state_d   = S_EN;
               cnt_d     = SET_LD;
               pad_d.ceb = 1'b0;
            end else cnt_d = cnt_q - 1'b1;
         end
         S_EN: begin
            if (rel) begin
               state_d   = S_DIS;
               cnt_d     = OFF_LD;
               pad_d.ceb = 1'b1;
            end else if (cnt_q == '0) begin
               state_d     = S_ACTIVE;
               pad_d.gnt   = own_1h;
               pad_d.ready = 1'b1;
`ifdef OBUFDS_GTE_REFCLK_CTRL_WATCHDOG_EN
               cnt_d       = HOLD_LD;
`endif
            end else cnt_d = cnt_q - 1'b1;
         end
         S_ACTIVE: begin
`ifdef OBUFDS_GTE_REFCLK_CTRL_WATCHDOG_EN
            if (own_req && cnt_q == '0) begin
               rel       = 1'b1;
               force_out = 1'b1;
               to_d      = 1'b1;
            end else if (own_req) cnt_d = cnt_q - 1'b1;
`endif
            if (rel) begin
               state_d     = S_DIS;
               cnt_d       = OFF_LD;
               pad_d.gnt   = '0;
               pad_d.ready = 1'b0;
               pad_d.ceb   = 1'b1;
            end
         end
         S_DIS: begin
            if (cnt_q == '0) begin
               state_d     = S_IDLE;
               pad_d.en    = 1'b0;
               pad_d.icntl = '0;
            end else cnt_d = cnt_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         pad_q     <= '0;
         pad_q.ceb <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         pad_q   <= pad_d;
      end
   end

`ifdef OBUFDS_GTE_REFCLK_CTRL_WATCHDOG_EN
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) to_q <= 1'b0;
      else       to_q <= to_d;
   end
`endif

   assign GNT        = pad_q.gnt;
   assign READY      = pad_q.ready;
   assign CEB        = pad_q.ceb;
   assign EN_TX_PATH = pad_q.en;
   assign ICNTL_TX   = pad_q.icntl;
endmodule

// File: tb/tb_obufds_gte_refclk_ctrl.sv
// Bench for obufds_gte_refclk_ctrl: timestamp-based reference model, grant scoreboard, directed and random phases.
`timescale 1ns/1ps
module tb_obufds_gte_refclk_ctrl;
   localparam int N = 4, C = 4, S = 16, OFF = 8, MAXH = 1024;

   logic           CLK = 1'b0;
   logic           RSTB = 1'b0;
   logic [N-1:0]   REQ = '0;
   logic [5*N-1:0] REQ_ICNTL = '0;
   logic [N-1:0]   GNT;
   logic           READY, CEB, EN_TX_PATH, TIMEOUT;
   logic [4:0]     ICNTL_TX;

   obufds_gte_refclk_ctrl #(
      .NUM_REQ(N), .CFG_CYCLES(C), .SETTLE_CYCLES(S), .OFF_CYCLES(OFF), .MAX_HOLD(MAXH)
   ) dut (
      .CLK(CLK), .RSTB(RSTB), .REQ(REQ), .REQ_ICNTL(REQ_ICNTL), .GNT(GNT), .READY(READY),
      .CEB(CEB), .EN_TX_PATH(EN_TX_PATH), .ICNTL_TX(ICNTL_TX), .TIMEOUT(TIMEOUT)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0, n_errors = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: ownership tracked as edge timestamps (arbitration, release).
   typedef struct { int idx; int icntl; int t; } gexp_t;
   gexp_t        sbq[$];
   bit           have_owner = 0;
   int           own = 0, t_arb = 0, t_rel = -1, ptr = 0;
   logic [4:0]   icn = '0;
   bit           m_to = 0;
   logic [N-1:0] blk = '0;

   always @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         have_owner = 0; ptr = 0; t_rel = -1; m_to = 0; blk = '0;
         sbq.delete();
      end else begin
         cyc++;
         if (!have_owner) begin
            if ((REQ & ~blk) != '0) begin
               for (int k = N - 1; k >= 0; k--)
                  if (REQ[(ptr + k) % N] && !blk[(ptr + k) % N]) own = (ptr + k) % N;
               have_owner = 1; t_arb = cyc; t_rel = -1;
               icn = REQ_ICNTL[5*own +: 5];
               ptr = (own + 1) % N;
            end
         end else if (t_rel < 0) begin
            if (!REQ[own]) t_rel = cyc;
            else if (cyc == t_arb + C + S) sbq.push_back('{own, int'(icn), cyc});
`ifdef OBUFDS_GTE_REFCLK_CTRL_WATCHDOG_EN
            else if (cyc == t_arb + C + S + MAXH) begin
               t_rel = cyc; m_to = 1; blk[own] = 1'b1;
            end
`endif
         end else if (cyc == t_rel + OFF) have_owner = 0;
         for (int i = 0; i < N; i++) if (!REQ[i]) blk[i] = 1'b0;
      end
   end

   // Monitor: per-cycle pad outputs vs model, grant events vs scoreboard.
   logic [N-1:0] prev_gnt = '0;
   bit           live;
   gexp_t        g;
   always @(negedge CLK) begin
      if (RSTB) begin
         live = have_owner && t_rel < 0;
         chk("en_tx_path", EN_TX_PATH, have_owner);
         chk("icntl_tx", ICNTL_TX, have_owner ? icn : 5'd0);
         chk("ceb", CEB, !(live && cyc >= t_arb + C));
         chk("gnt", GNT, (live && cyc >= t_arb + C + S) ? (1 << own) : 0);
         chk("ready", READY, live && cyc >= t_arb + C + S);
         chk("timeout", TIMEOUT, m_to);
         if (GNT != '0 && prev_gnt == '0) begin
            if (sbq.size() == 0) chk("unexpected_grant", GNT, 0);
            else begin
               g = sbq.pop_front();
               chk("sb_owner", GNT, 1 << g.idx);
               chk("sb_icntl", ICNTL_TX, g.icntl);
               chk("sb_time", cyc, g.t);
            end
         end
      end
      prev_gnt = GNT;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic set_icntl(input int i, input logic [4:0] v);
      REQ_ICNTL[5*i +: 5] = v;
   endtask

   task automatic wait_gnt(output int idx);
      idx = -1;
      for (int k = 0; k < 200; k++) begin
         tick(1);
         if (GNT != '0) begin
            for (int i = 0; i < N; i++) if (GNT[i]) idx = i;
            return;
         end
      end
      chk("grant_wait_timeout", 1, 0);
   endtask

   initial begin
      int idx, t0, rel_edge;
      tick(3);
      chk("rst_gnt", GNT, 0); chk("rst_ready", READY, 0); chk("rst_ceb", CEB, 1);
      chk("rst_en", EN_TX_PATH, 0); chk("rst_icntl", ICNTL_TX, 0); chk("rst_timeout", TIMEOUT, 0);
      RSTB = 1'b1;
      tick(5);

      // single request, then reset while ACTIVE
      set_icntl(2, 5'h13); REQ = 4'b0100; t0 = cyc + 1;
      wait_gnt(idx);
      chk("single_owner", idx, 2);
      chk("single_latency", cyc - t0, C + S);
      chk("single_icntl", ICNTL_TX, 5'h13);
      tick(3);
      RSTB = 1'b0; #1;
      chk("midrst_gnt", GNT, 0); chk("midrst_ready", READY, 0); chk("midrst_ceb", CEB, 1);
      chk("midrst_en", EN_TX_PATH, 0); chk("midrst_icntl", ICNTL_TX, 0);
      REQ = '0;
      tick(2); RSTB = 1'b1; tick(2);

      // round robin with all requesters held
      for (int i = 0; i < N; i++) set_icntl(i, 5'(i + 4));
      REQ = '1; rel_edge = 0;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(idx);
         chk("rr_order", idx, k % N);
         if (k > 0) chk("rr_gap", cyc - rel_edge, OFF + 1 + C + S);
         tick(5);
         if (idx >= 0) REQ[idx] = 1'b0;
         rel_edge = cyc + 1;
         tick(1);
         if (idx >= 0) REQ[idx] = 1'b1;
      end
      REQ = '0; tick(OFF + 4);

      // abort during EN
      set_icntl(0, 5'h07); REQ = 4'b0001;
      for (int k = 0; k < 50 && CEB !== 1'b0; k++) tick(1);
      chk("abort_reach_en", CEB, 0);
      tick(2); REQ[0] = 1'b0; tick(1);
      chk("abort_ceb", CEB, 1); chk("abort_gnt", GNT, 0);
      tick(OFF - 1); chk("abort_dis_hold", EN_TX_PATH, 1);
      tick(1);       chk("abort_idle", EN_TX_PATH, 0);
      tick(3);

      // request arriving on the DIS-expiry edge with PTR=1
      REQ = 4'b0001;
      wait_gnt(idx); chk("simul_first", idx, 0);
      tick(2); REQ[0] = 1'b0; t0 = cyc + 1;
      tick(OFF);
      set_icntl(1, 5'h0A); REQ[1] = 1'b1;
      wait_gnt(idx);
      chk("simul_owner", idx, 1);
      chk("simul_gap", cyc - t0, OFF + 1 + C + S);
      set_icntl(1, 5'h1F); tick(2);
      chk("icntl_locked", ICNTL_TX, 5'h0A);
      REQ = '0; tick(OFF + 4);

      // long hold
      set_icntl(2, 5'h15); REQ = 4'b0100;
      wait_gnt(idx); t0 = cyc;
`ifdef OBUFDS_GTE_REFCLK_CTRL_WATCHDOG_EN
      for (int k = 0; k < MAXH + 10 && GNT != '0; k++) tick(1);
      chk("wd_forced", GNT, 0);
      chk("wd_hold_cycles", cyc - t0, MAXH);
      chk("wd_timeout", TIMEOUT, 1);
      tick(60); chk("wd_no_regrant", GNT, 0);
      REQ[2] = 1'b0; tick(2); REQ[2] = 1'b1;
      wait_gnt(idx); chk("wd_regrant", idx, 2);
      chk("wd_sticky", TIMEOUT, 1);
`else
      tick(MAXH + 50);
      chk("hold_active", GNT, 4'b0100);
      chk("hold_timeout", TIMEOUT, 0);
`endif
      REQ = '0; tick(OFF + 4);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!REQ[i]) begin
               if ($urandom_range(7) == 0) begin REQ[i] = 1'b1; set_icntl(i, 5'($urandom_range(31))); end
            end else if (GNT[i]) begin
               if ($urandom_range(5) == 0) REQ[i] = 1'b0;
            end else if ($urandom_range(59) == 0) REQ[i] = 1'b0;
            if ($urandom_range(15) == 0) set_icntl(i, 5'($urandom_range(31)));
         end
         tick(1);
      end
      REQ = '0; tick(40);
      chk("scoreboard_drained", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
